// File: rtl/engine_sched_if.sv
// Command, engine and DMA handshake bundle for the layer scheduler.
// slave is the scheduler's view; master is the surrounding command/engine/DMA side.
interface engine_sched_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_stride;
  logic [7:0]  cmd_kernel;
  logic [7:0]  cmd_i_side;
  logic [7:0]  cmd_o_side;
  logic [15:0] cmd_i_channel;
  logic [15:0] cmd_o_channel;
  logic [2:0]  op_type;
  logic [3:0]  stride;
  logic [7:0]  kernel;
  logic [7:0]  i_side;
  logic [7:0]  o_side;
  logic [15:0] i_channel;
  logic [15:0] o_channel;
  logic [7:0]  kernel_size;
  logic [15:0] stride2;
  logic        engine_rst;
  logic        engine_valid;
  logic        gemm_finish;
  logic        load_req;
  logic        load_ack;
  logic        wb_done;
  logic [7:0]  row_idx;
  logic [15:0] group_idx;
  logic        busy;
  logic        layer_done;
  logic [1:0]  err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_stride, cmd_kernel, cmd_i_side, cmd_o_side,
           cmd_i_channel, cmd_o_channel, gemm_finish, load_ack, wb_done,
    output cmd_ready, op_type, stride, kernel, i_side, o_side, i_channel, o_channel,
           kernel_size, stride2, engine_rst, engine_valid, load_req, row_idx,
           group_idx, busy, layer_done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_stride, cmd_kernel, cmd_i_side, cmd_o_side,
           cmd_i_channel, cmd_o_channel, gemm_finish, load_ack, wb_done,
    input  cmd_ready, op_type, stride, kernel, i_side, o_side, i_channel, o_channel,
           kernel_size, stride2, engine_rst, engine_valid, load_req, row_idx,
           group_idx, busy, layer_done, err
  );
endinterface

// File: rtl/engine_sched.sv
// Layer scheduler: latches one layer command and sequences it into engine passes,
// rows inner and channel groups of BURST_LEN outer, with a per-pass RUN watchdog.
module engine_sched #(
  parameter int unsigned BURST_LEN = 8,
  parameter logic [31:0] TIMEOUT   = 32'd1_000_000
) (
  input logic           clk,
  input logic           rst,
  engine_sched_if.slave bus
);
  localparam int unsigned LG = $clog2(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_ERST, S_LOAD, S_RUN, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [3:0]  r_stride;
  logic [7:0]  r_kernel, r_i_side, r_o_side;
  logic [15:0] r_i_channel, r_o_channel;
  logic [7:0]  r_kernel_size;
  logic [15:0] r_stride2;
  logic [16:0] r_n_groups;
  logic [7:0]  r_n_rows;
  logic [7:0]  r_row;
  logic [15:0] r_group;
  logic [1:0]  r_err;
  logic [31:0] r_wd;

  logic        w_accept, w_bad, w_timeout, w_row_more, w_grp_more;
  logic [31:0] w_wd_inc;
  logic [7:0]  w_ksq;
  logic [15:0] w_s2;
  logic [16:0] w_groups;

  assign w_accept   = (r_state == S_IDLE) && bus.cmd_valid;
  // Validation runs on the latched copy in CALC, so a rejected command still spends one CALC cycle.
  assign w_bad      = (r_op == 3'd0) || (r_op > 3'd3) || (r_kernel == '0) ||
                      (r_o_side == '0) || (r_o_channel == '0);
  assign w_wd_inc   = (r_wd == '1) ? r_wd : r_wd + 32'd1;
  assign w_timeout  = (w_wd_inc >= TIMEOUT);
  assign w_row_more = ({1'b0, r_row} + 9'd1) < {1'b0, r_n_rows};
  assign w_grp_more = ({1'b0, r_group} + 17'd1) < r_n_groups;
  assign w_ksq      = r_kernel * r_kernel;
  assign w_s2       = 16'(r_kernel) * 16'(r_stride);
  assign w_groups   = ({1'b0, r_o_channel} + 17'(BURST_LEN - 1)) >> LG;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CALC;
      S_CALC:  w_next = w_bad ? S_DONE : S_ERST;
      S_ERST:  w_next = S_LOAD;
      S_LOAD:  if (bus.load_ack) w_next = S_RUN;
      S_RUN: begin
        if (bus.gemm_finish)  w_next = S_DRAIN;
        else if (w_timeout)   w_next = S_DONE;
      end
      S_DRAIN: if (bus.wb_done) w_next = S_NEXT;
      S_NEXT:  w_next = (w_row_more || w_grp_more) ? S_ERST : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op          <= '0;
      r_stride      <= '0;
      r_kernel      <= '0;
      r_i_side      <= '0;
      r_o_side      <= '0;
      r_i_channel   <= '0;
      r_o_channel   <= '0;
      r_kernel_size <= '0;
      r_stride2     <= '0;
      r_n_groups    <= '0;
      r_n_rows      <= '0;
      r_row         <= '0;
      r_group       <= '0;
      r_err         <= '0;
      r_wd          <= '0;
    end else begin
      r_wd <= (r_state == S_RUN) ? w_wd_inc : '0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op        <= bus.cmd_op;
          r_stride    <= bus.cmd_stride;
          r_kernel    <= bus.cmd_kernel;
          r_i_side    <= bus.cmd_i_side;
          r_o_side    <= bus.cmd_o_side;
          r_i_channel <= bus.cmd_i_channel;
          r_o_channel <= bus.cmd_o_channel;
          r_row       <= '0;
          r_group     <= '0;
          r_err       <= '0;
        end
        S_CALC: begin
          r_kernel_size <= w_ksq;
          r_stride2     <= w_s2;
          r_n_groups    <= w_groups;
          r_n_rows      <= (r_op == 3'd3) ? 8'd1 : r_o_side;
          if (w_bad) r_err <= 2'd1;
        end
        S_RUN: if (!bus.gemm_finish && w_timeout) r_err <= 2'd2;
        S_NEXT: begin
          if (w_row_more) begin
            r_row <= r_row + 8'd1;
          end else begin
            r_row <= '0;
            if (w_grp_more) r_group <= r_group + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready    = (r_state == S_IDLE) && !rst;
  assign bus.engine_rst   = (r_state == S_ERST);
  assign bus.load_req     = (r_state == S_LOAD);
  assign bus.engine_valid = (r_state == S_RUN);
  assign bus.layer_done   = (r_state == S_DONE);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.op_type      = r_op;
  assign bus.stride       = r_stride;
  assign bus.kernel       = r_kernel;
  assign bus.i_side       = r_i_side;
  assign bus.o_side       = r_o_side;
  assign bus.i_channel    = r_i_channel;
  assign bus.o_channel    = r_o_channel;
  assign bus.kernel_size  = r_kernel_size;
  assign bus.stride2      = r_stride2;
  assign bus.row_idx      = r_row;
  assign bus.group_idx    = r_group;
  assign bus.err          = r_err;
endmodule

// File: tb/tb_engine_sched.sv
// Bench for engine_sched: table of layer commands, hand-written reset/abort sequence,
// and random commands checked against a pass-level reference model.
module tb_engine_sched;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  engine_sched_if bus();

  engine_sched #(.BURST_LEN(8), .TIMEOUT(32'd16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  st;
    logic [7:0]  k;
    logic [7:0]  osd;
    logic [15:0] och;
    int          ack_d;
    int          run_d;   // negative: engine never finishes
    int          wb_d;
    logic [1:0]  e_err;
    logic [7:0]  e_ks;
    logic [15:0] e_s2;
    int          e_rows;
    int          e_groups;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint ctl_vec();
    return longint'({bus.cmd_ready, bus.engine_rst, bus.engine_valid, bus.load_req, bus.busy,
                     bus.layer_done, bus.err, bus.row_idx, bus.group_idx});
  endfunction

  function automatic longint cfg_vec();
    return longint'({bus.op_type, bus.stride, bus.kernel, bus.i_side, bus.o_side,
                     bus.i_channel, bus.o_channel});
  endfunction

  function automatic vec_t mk(input int op, st, k, osd, och, ack_d, run_d, wb_d,
                              input int e_err, e_ks, e_s2, e_rows, e_groups);
    vec_t v;
    v.op = 3'(op); v.st = 4'(st); v.k = 8'(k); v.osd = 8'(osd); v.och = 16'(och);
    v.ack_d = ack_d; v.run_d = run_d; v.wb_d = wb_d;
    v.e_err = 2'(e_err); v.e_ks = 8'(e_ks); v.e_s2 = 16'(e_s2);
    v.e_rows = e_rows; v.e_groups = e_groups;
    return v;
  endfunction

  // Layer-level expectations straight from the command fields.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    r = v;
    r.e_rows   = (v.op == 3'd3) ? 1 : int'(v.osd);
    r.e_groups = (int'(v.och) + 7) / 8;
    r.e_ks     = 8'((int'(v.k) * int'(v.k)) % 256);
    r.e_s2     = 16'(int'(v.k) * int'(v.st));
    if (v.op < 3'd1 || v.op > 3'd3 || v.k == 0 || v.osd == 0 || v.och == 0) r.e_err = 2'd1;
    else if (v.run_d < 0 || v.run_d + 1 > TO)                               r.e_err = 2'd2;
    else                                                                     r.e_err = 2'd0;
    return r;
  endfunction

  task automatic run_cmd(input vec_t v, input bit noise, input int abort_pass);
    int t, t_done, n_rst, n_load, n_valid, lcnt, rcnt, dcnt, exp_p, exp_lat, wb_stage;
    bit excl_ok, seq_ok, ord_ok, fin_drv, in_drain, ack_prev;
    logic [7:0]  ish;
    logic [15:0] ich;
    int rows_q[$];
    int grps_q[$];
    t_done = -1; n_rst = 0; n_load = 0; n_valid = 0; lcnt = 0; rcnt = 0; dcnt = 0;
    wb_stage = 0; excl_ok = 1; seq_ok = 1; ord_ok = 1; fin_drv = 0; in_drain = 0; ack_prev = 0;
    ish = 8'($urandom); ich = 16'($urandom);
    bus.cmd_op = v.op; bus.cmd_stride = v.st; bus.cmd_kernel = v.k; bus.cmd_i_side = ish;
    bus.cmd_o_side = v.osd; bus.cmd_i_channel = ich; bus.cmd_o_channel = v.och;
    chk("ready_idle", longint'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    t = 1;
    while (t < 4000) begin
      if (int'(bus.engine_rst) + int'(bus.load_req) + int'(bus.engine_valid) > 1) excl_ok = 0;
      if (ack_prev && (!bus.engine_valid || bus.load_req)) seq_ok = 0;
      ack_prev = 0;
      if (wb_stage == 2) begin
        if (!(bus.engine_rst || bus.layer_done)) seq_ok = 0;
        wb_stage = 0;
      end
      if (wb_stage == 1) begin
        if (bus.engine_rst || bus.load_req || bus.engine_valid || bus.layer_done || !bus.busy)
          seq_ok = 0;
        wb_stage = 2;
      end
      if (bus.layer_done) begin
        t_done = t;
        break;
      end
      if (bus.engine_rst) begin
        rows_q.push_back(int'(bus.row_idx));
        grps_q.push_back(int'(bus.group_idx));
        n_rst++;
      end
      if (abort_pass > 0 && bus.engine_valid && n_rst == abort_pass) begin
        #2 rst = 1'b1;
        #1;
        chk("abort_ctl", ctl_vec(), 0);
        chk("abort_cfg", cfg_vec(), 0);
        chk("abort_calc", longint'({bus.kernel_size, bus.stride2}), 0);
        bus.load_ack = 1'b0; bus.gemm_finish = 1'b0; bus.wb_done = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        chk("abort_release", ctl_vec(), longint'(32'h8000_0000));
        return;
      end
      if (!bus.engine_valid && fin_drv) begin
        in_drain = 1; fin_drv = 0; dcnt = 0;
      end
      bus.load_ack = 1'b0;
      if (bus.load_req) begin
        n_load++;
        if (lcnt == v.ack_d) begin bus.load_ack = 1'b1; ack_prev = 1; end
        lcnt++;
      end else lcnt = 0;
      bus.gemm_finish = 1'b0;
      if (bus.engine_valid) begin
        n_valid++;
        if (rcnt == v.run_d) begin bus.gemm_finish = 1'b1; fin_drv = 1; end
        rcnt++;
      end else rcnt = 0;
      bus.wb_done = 1'b0;
      if (in_drain) begin
        if (dcnt == v.wb_d) begin bus.wb_done = 1'b1; in_drain = 0; wb_stage = 1; end
        dcnt++;
      end
      if (noise) begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 3'($urandom);
        bus.cmd_kernel = 8'($urandom);
      end
      tick();
      t++;
    end
    bus.load_ack = 1'b0; bus.gemm_finish = 1'b0; bus.wb_done = 1'b0;
    if (t_done < 0) begin
      chk("layer_done_bound", 0, 1);
      return;
    end
    exp_p   = (v.e_err == 2'd1) ? 0 : (v.e_err == 2'd2) ? 1 : v.e_rows * v.e_groups;
    exp_lat = (v.e_err == 2'd1) ? 2 : (v.e_err == 2'd2) ? 20 + v.ack_d
                                    : 2 + exp_p * (5 + v.ack_d + v.run_d + v.wb_d);
    for (int i = 0; i < rows_q.size() && i < exp_p; i++)
      if (rows_q[i] != i % v.e_rows || grps_q[i] != i / v.e_rows) ord_ok = 0;
    chk("latency", t_done, exp_lat);
    chk("err", longint'(bus.err), longint'(v.e_err));
    chk("passes", n_rst, exp_p);
    chk("pass_order", ord_ok, 1);
    chk("load_cycles", n_load, (v.e_err == 2'd1) ? 0 : exp_p * (v.ack_d + 1));
    chk("run_cycles", n_valid, (v.e_err == 2'd1) ? 0 : (v.e_err == 2'd2) ? TO
                                                  : exp_p * (v.run_d + 1));
    chk("exclusive", excl_ok, 1);
    chk("handshake_timing", seq_ok, 1);
    chk("cfg", cfg_vec(), longint'({v.op, v.st, v.k, ish, v.osd, ich, v.och}));
    if (v.e_err != 2'd1) begin
      chk("kernel_size", longint'(bus.kernel_size), longint'(v.e_ks));
      chk("stride2", longint'(bus.stride2), longint'(v.e_s2));
    end
    tick();
    bus.cmd_valid = 1'b0;
    chk("done_pulse", longint'({bus.layer_done, bus.busy, bus.cmd_ready}), 1);
    chk("err_held", longint'(bus.err), longint'(v.e_err));
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_stride = '0; bus.cmd_kernel = '0;
    bus.cmd_i_side = '0; bus.cmd_o_side = '0; bus.cmd_i_channel = '0; bus.cmd_o_channel = '0;
    bus.gemm_finish = 1'b0; bus.load_ack = 1'b0; bus.wb_done = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", ctl_vec(), 0);
    chk("reset_cfg", cfg_vec(), 0);
    chk("reset_calc", longint'({bus.kernel_size, bus.stride2}), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", longint'(bus.cmd_ready), 1);

    //          op st  k osd och ack run wb | err ks  s2 rows grp
    tbl.push_back(mk(1, 1,  3, 4, 16, 0,  0, 0,  0, 9,   3,  4, 2));
    tbl.push_back(mk(3, 1,  2,13, 10, 0,  1, 0,  0, 4,   2,  1, 2));
    tbl.push_back(mk(0, 1,  3, 4, 16, 0,  0, 0,  1, 0,   0,  0, 0));
    tbl.push_back(mk(1, 1,  0, 4, 16, 0,  0, 0,  1, 0,   0,  0, 0));
    tbl.push_back(mk(2, 2,  2, 2,  8, 1,  2, 1,  0, 4,   4,  2, 1));
    tbl.push_back(mk(1, 1,  1, 2,  8, 0, -1, 0,  2, 1,   1,  2, 1));
    tbl.push_back(mk(1, 2,  3, 2,  9, 5,  2, 7,  0, 9,   6,  2, 2));
    tbl.push_back(mk(1, 1,  1, 1,  8, 0, 15, 0,  0, 1,   1,  1, 1));
    tbl.push_back(mk(1, 1,  1, 1,  8, 0, 16, 0,  2, 1,   1,  1, 1));
    tbl.push_back(mk(1,15, 16, 1,  1, 0,  0, 0,  0, 0, 240,  1, 1));
    tbl.push_back(mk(2, 1,  3, 0,  8, 0,  0, 0,  1, 0,   0,  0, 0));
    tbl.push_back(mk(1, 1,  3, 2,  0, 0,  0, 0,  1, 0,   0,  0, 0));
    tbl.push_back(mk(4, 1,  3, 2,  8, 0,  0, 0,  1, 0,   0,  0, 0));
    tbl.push_back(mk(1, 1,  2, 3,  8, 0, 12, 0,  0, 4,   2,  3, 1));
    tbl.push_back(mk(3, 1,  2, 5,  8, 2,  0, 3,  0, 4,   2,  1, 1));
    for (int i = 0; i < tbl.size(); i++) run_cmd(tbl[i], 1'b0, 0);

    // Reset during RUN of the third pass, then a fresh layer must restart at row 0, group 0.
    run_cmd(mk(1, 1, 3, 4, 16, 0, 3, 0, 0, 9, 3, 4, 2), 1'b0, 3);
    repeat (3) begin
      chk("no_done_after_abort", longint'(bus.layer_done), 0);
      tick();
    end
    run_cmd(mk(1, 1, 2, 2, 8, 0, 1, 0, 0, 4, 2, 2, 1), 1'b0, 0);

    for (int n = 0; n < 25; n++) begin
      v.op    = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 3));
      v.st    = 4'($urandom_range(0, 15));
      v.k     = 8'($urandom_range(0, 6));
      v.osd   = 8'($urandom_range(0, 4));
      v.och   = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 24));
      v.ack_d = int'($urandom_range(0, 3));
      v.run_d = int'($urandom_range(0, 18));
      v.wb_d  = int'($urandom_range(0, 3));
      v = ref_model(v);
      run_cmd(v, 1'b1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
